// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded control and operands, detects
// load-use hazards against the instruction in EX and inserts bubbles.
module id_ex_stage #(
  parameter int NB_DATA  = 32,
  parameter int NB_REG   = 5,
  parameter int NB_ALUOP = 2,
  parameter int NB_CNT   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_enable,
  input  logic                i_valid,
  input  logic                i_flush,
  input  logic                i_RegDst,
  input  logic                i_ALUSrc,
  input  logic                i_Branch,
  input  logic                i_MemRead,
  input  logic                i_MemWrite,
  input  logic                i_RegWrite,
  input  logic                i_MemtoReg,
  input  logic [NB_ALUOP-1:0] i_ALUOp,
  input  logic [NB_DATA-1:0]  i_pc_next,
  input  logic [NB_DATA-1:0]  i_rs_data,
  input  logic [NB_DATA-1:0]  i_rt_data,
  input  logic [NB_DATA-1:0]  i_imm,
  input  logic [NB_REG-1:0]   i_rs,
  input  logic [NB_REG-1:0]   i_rt,
  input  logic [NB_REG-1:0]   i_rd,
  output logic                o_RegDst,
  output logic                o_ALUSrc,
  output logic                o_Branch,
  output logic                o_MemRead,
  output logic                o_MemWrite,
  output logic                o_RegWrite,
  output logic                o_MemtoReg,
  output logic [NB_ALUOP-1:0] o_ALUOp,
  output logic [NB_DATA-1:0]  o_pc_next,
  output logic [NB_DATA-1:0]  o_rs_data,
  output logic [NB_DATA-1:0]  o_rt_data,
  output logic [NB_DATA-1:0]  o_imm,
  output logic [NB_REG-1:0]   o_rs,
  output logic [NB_REG-1:0]   o_rt,
  output logic [NB_REG-1:0]   o_rd,
  output logic                o_valid,
  output logic                o_stall,
  output logic [NB_CNT-1:0]   o_bubble_cnt
);

  logic hz;

  // Load in EX whose destination (rt) is a source of the decode instruction.
  always_comb begin
    hz = i_valid & o_valid & o_MemRead & (o_rt != '0) &
         ((o_rt == i_rs) | (o_rt == i_rt));
    o_stall = hz & ~i_flush & i_enable;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_RegDst     <= 1'b0;
      o_ALUSrc     <= 1'b0;
      o_Branch     <= 1'b0;
      o_MemRead    <= 1'b0;
      o_MemWrite   <= 1'b0;
      o_RegWrite   <= 1'b0;
      o_MemtoReg   <= 1'b0;
      o_ALUOp      <= '0;
      o_pc_next    <= '0;
      o_rs_data    <= '0;
      o_rt_data    <= '0;
      o_imm        <= '0;
      o_rs         <= '0;
      o_rt         <= '0;
      o_rd         <= '0;
      o_valid      <= 1'b0;
      o_bubble_cnt <= '0;
    end else if (i_enable) begin
      if (i_flush || hz) begin
        o_RegDst   <= 1'b0;
        o_ALUSrc   <= 1'b0;
        o_Branch   <= 1'b0;
        o_MemRead  <= 1'b0;
        o_MemWrite <= 1'b0;
        o_RegWrite <= 1'b0;
        o_MemtoReg <= 1'b0;
        o_ALUOp    <= '0;
        o_pc_next  <= '0;
        o_rs_data  <= '0;
        o_rt_data  <= '0;
        o_imm      <= '0;
        o_rs       <= '0;
        o_rt       <= '0;
        o_rd       <= '0;
        o_valid    <= 1'b0;
        // Only hazard bubbles are counted; flush takes priority.
        if (!i_flush && o_bubble_cnt != '1)
          o_bubble_cnt <= o_bubble_cnt + NB_CNT'(1);
      end else begin
        o_RegDst   <= i_RegDst   & i_valid;
        o_ALUSrc   <= i_ALUSrc   & i_valid;
        o_Branch   <= i_Branch   & i_valid;
        o_MemRead  <= i_MemRead  & i_valid;
        o_MemWrite <= i_MemWrite & i_valid;
        o_RegWrite <= i_RegWrite & i_valid;
        o_MemtoReg <= i_MemtoReg & i_valid;
        o_ALUOp    <= i_valid ? i_ALUOp : '0;
        o_pc_next  <= i_pc_next;
        o_rs_data  <= i_rs_data;
        o_rt_data  <= i_rt_data;
        o_imm      <= i_imm;
        o_rs       <= i_rs;
        o_rt       <= i_rt;
        o_rd       <= i_rd;
        o_valid    <= i_valid;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage (bubble counter narrowed to 2 bits to reach saturation).
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_enable, i_valid, i_flush;
  logic        i_RegDst, i_ALUSrc, i_Branch, i_MemRead, i_MemWrite, i_RegWrite, i_MemtoReg;
  logic [1:0]  i_ALUOp;
  logic [31:0] i_pc_next, i_rs_data, i_rt_data, i_imm;
  logic [4:0]  i_rs, i_rt, i_rd;
  logic        o_RegDst, o_ALUSrc, o_Branch, o_MemRead, o_MemWrite, o_RegWrite, o_MemtoReg;
  logic [1:0]  o_ALUOp;
  logic [31:0] o_pc_next, o_rs_data, o_rt_data, o_imm;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic        o_valid, o_stall;
  logic [1:0]  o_bubble_cnt;

  int errors = 0;
  int checks = 0;

  localparam logic [8:0] CTRL_R  = 9'b1_0_0_0_0_1_0_10;
  localparam logic [8:0] CTRL_LW = 9'b0_1_0_1_0_1_1_00;

  logic [8:0]   ctrl;
  logic [127:0] data;
  logic [14:0]  idx;
  assign ctrl = {o_RegDst, o_ALUSrc, o_Branch, o_MemRead, o_MemWrite, o_RegWrite, o_MemtoReg, o_ALUOp};
  assign data = {o_pc_next, o_rs_data, o_rt_data, o_imm};
  assign idx  = {o_rs, o_rt, o_rd};

  id_ex_stage #(.NB_DATA(32), .NB_REG(5), .NB_ALUOP(2), .NB_CNT(2)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_valid(i_valid), .i_flush(i_flush),
    .i_RegDst(i_RegDst), .i_ALUSrc(i_ALUSrc), .i_Branch(i_Branch), .i_MemRead(i_MemRead),
    .i_MemWrite(i_MemWrite), .i_RegWrite(i_RegWrite), .i_MemtoReg(i_MemtoReg),
    .i_ALUOp(i_ALUOp), .i_pc_next(i_pc_next), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
    .i_imm(i_imm), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd),
    .o_RegDst(o_RegDst), .o_ALUSrc(o_ALUSrc), .o_Branch(o_Branch), .o_MemRead(o_MemRead),
    .o_MemWrite(o_MemWrite), .o_RegWrite(o_RegWrite), .o_MemtoReg(o_MemtoReg),
    .o_ALUOp(o_ALUOp), .o_pc_next(o_pc_next), .o_rs_data(o_rs_data), .o_rt_data(o_rt_data),
    .o_imm(o_imm), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
    .o_valid(o_valid), .o_stall(o_stall), .o_bubble_cnt(o_bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn;
    i_valid = 0; i_flush = 0;
    i_RegDst = 0; i_ALUSrc = 0; i_Branch = 0; i_MemRead = 0;
    i_MemWrite = 0; i_RegWrite = 0; i_MemtoReg = 0; i_ALUOp = '0;
    i_pc_next = '0; i_rs_data = '0; i_rt_data = '0; i_imm = '0;
    i_rs = '0; i_rt = '0; i_rd = '0;
  endtask

  task automatic setLoad(input logic [4:0] rs, input logic [4:0] rt);
    clearIn();
    i_valid = 1; i_ALUSrc = 1; i_MemRead = 1; i_RegWrite = 1; i_MemtoReg = 1;
    i_pc_next = 32'h200; i_rs_data = 32'h1000; i_imm = 32'h4;
    i_rs = rs; i_rt = rt;
  endtask

  task automatic setRtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    clearIn();
    i_valid = 1; i_RegDst = 1; i_RegWrite = 1; i_ALUOp = 2'b10;
    i_pc_next = 32'h104; i_rs_data = 32'h11; i_rt_data = 32'h22; i_imm = 32'h33;
    i_rs = rs; i_rt = rt; i_rd = rd;
  endtask

  task automatic test_reset_initial;
    #1 rst = 1;
    #1;
    checks++; if (ctrl !== 9'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected %h", ctrl, 9'h0); end
    checks++; if ({data, idx, o_valid} !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", {data, idx, o_valid}); end
    checks++; if (o_bubble_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", o_bubble_cnt); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_passthrough;
    setRtype(5'd1, 5'd2, 5'd3);
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL pass_stall_pre: got %b expected 0", o_stall); end
    tick();
    checks++; if (ctrl !== CTRL_R) begin errors++; $display("FAIL pass_ctrl: got %h expected %h", ctrl, CTRL_R); end
    checks++; if (data !== {32'h104, 32'h11, 32'h22, 32'h33}) begin errors++; $display("FAIL pass_data: got %h expected %h", data, {32'h104, 32'h11, 32'h22, 32'h33}); end
    checks++; if (idx !== {5'd1, 5'd2, 5'd3}) begin errors++; $display("FAIL pass_idx: got %h expected %h", idx, {5'd1, 5'd2, 5'd3}); end
    checks++; if ({o_valid, o_stall} !== 2'b10) begin errors++; $display("FAIL pass_valid_stall: got %b expected 10", {o_valid, o_stall}); end
    // invalid decode slot: controls forced off, data still captured
    i_valid = 0;
    tick();
    checks++; if ({ctrl, o_valid} !== 10'h0) begin errors++; $display("FAIL invalid_ctrl: got %h expected 0", {ctrl, o_valid}); end
    checks++; if (o_rs_data !== 32'h11) begin errors++; $display("FAIL invalid_data: got %h expected 11", o_rs_data); end
  endtask

  task automatic test_load_use;
    setLoad(5'd0, 5'd5);
    tick();
    checks++; if (ctrl !== CTRL_LW || o_rt !== 5'd5) begin errors++; $display("FAIL lu_load: got %h/%0d expected %h/5", ctrl, o_rt, CTRL_LW); end
    setRtype(5'd5, 5'd6, 5'd7);
    #1;
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b expected 1", o_stall); end
    tick();
    checks++; if ({ctrl, o_valid} !== 10'h0 || data !== '0) begin errors++; $display("FAIL lu_bubble: got %h expected 0", {ctrl, o_valid}); end
    checks++; if (o_bubble_cnt !== 2'd1) begin errors++; $display("FAIL lu_cnt: got %0d expected 1", o_bubble_cnt); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL lu_stall_clear: got %b expected 0", o_stall); end
    tick();
    checks++; if (ctrl !== CTRL_R || idx !== {5'd5, 5'd6, 5'd7} || o_valid !== 1'b1) begin errors++; $display("FAIL lu_advance: got %h %h expected %h %h", ctrl, idx, CTRL_R, {5'd5, 5'd6, 5'd7}); end
  endtask

  task automatic test_reset_async;
    setLoad(5'd0, 5'd5);
    tick();
    setRtype(5'd5, 5'd6, 5'd7);
    #1;
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL ar_pre_stall: got %b expected 1", o_stall); end
    #1 rst = 1;
    #1;
    checks++; if ({ctrl, data, idx, o_valid} !== '0) begin errors++; $display("FAIL ar_outputs: got nonzero ctrl %h expected 0", ctrl); end
    checks++; if ({o_stall, o_bubble_cnt} !== 3'b000) begin errors++; $display("FAIL ar_stall_cnt: got %b expected 000", {o_stall, o_bubble_cnt}); end
    #1 rst = 0;
    clearIn();
  endtask

  task automatic test_no_dependence;
    setLoad(5'd1, 5'd0);
    tick();
    setRtype(5'd0, 5'd0, 5'd3);
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL nd_zero_stall: got %b expected 0", o_stall); end
    tick();
    checks++; if (o_valid !== 1'b1 || ctrl !== CTRL_R) begin errors++; $display("FAIL nd_zero_capture: got %b %h expected 1 %h", o_valid, ctrl, CTRL_R); end
    setLoad(5'd1, 5'd5);
    tick();
    setRtype(5'd6, 5'd7, 5'd8);
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL nd_indep_stall: got %b expected 0", o_stall); end
    tick();
    checks++; if (idx !== {5'd6, 5'd7, 5'd8} || o_valid !== 1'b1) begin errors++; $display("FAIL nd_indep_capture: got %h expected %h", idx, {5'd6, 5'd7, 5'd8}); end
    checks++; if (o_bubble_cnt !== 2'd0) begin errors++; $display("FAIL nd_cnt: got %0d expected 0", o_bubble_cnt); end
  endtask

  task automatic test_flush;
    setLoad(5'd0, 5'd5);
    tick();
    setRtype(5'd2, 5'd5, 5'd9);
    i_flush = 1;
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL fl_stall: got %b expected 0", o_stall); end
    tick();
    checks++; if ({ctrl, data, idx, o_valid} !== '0) begin errors++; $display("FAIL fl_bubble: got ctrl %h idx %h expected 0", ctrl, idx); end
    checks++; if (o_bubble_cnt !== 2'd0) begin errors++; $display("FAIL fl_cnt: got %0d expected 0", o_bubble_cnt); end
    i_flush = 0;
  endtask

  task automatic test_enable;
    setLoad(5'd0, 5'd5);
    tick();
    setRtype(5'd5, 5'd6, 5'd7);
    i_enable = 0;
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL en_stall: got %b expected 0", o_stall); end
    repeat (3) tick();
    checks++; if (ctrl !== CTRL_LW || o_rt !== 5'd5 || o_valid !== 1'b1) begin errors++; $display("FAIL en_hold: got %h rt %0d expected %h rt 5", ctrl, o_rt, CTRL_LW); end
    checks++; if (o_bubble_cnt !== 2'd0) begin errors++; $display("FAIL en_cnt_hold: got %0d expected 0", o_bubble_cnt); end
    i_enable = 1;
    #1;
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL en_resume_stall: got %b expected 1", o_stall); end
    tick();
    checks++; if (o_bubble_cnt !== 2'd1 || o_valid !== 1'b0) begin errors++; $display("FAIL en_resume_bubble: got %0d %b expected 1 0", o_bubble_cnt, o_valid); end
  endtask

  task automatic test_back_to_back;
    setLoad(5'd0, 5'd5);
    tick();
    setLoad(5'd5, 5'd8);
    #1;
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL b2b_stall1: got %b expected 1", o_stall); end
    tick();
    checks++; if (o_bubble_cnt !== 2'd2 || o_MemRead !== 1'b0) begin errors++; $display("FAIL b2b_bubble: got %0d %b expected 2 0", o_bubble_cnt, o_MemRead); end
    tick();
    checks++; if (ctrl !== CTRL_LW || o_rt !== 5'd8) begin errors++; $display("FAIL b2b_load2: got %h rt %0d expected %h rt 8", ctrl, o_rt, CTRL_LW); end
    setRtype(5'd1, 5'd8, 5'd9);
    #1;
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL b2b_stall2: got %b expected 1", o_stall); end
    tick();
    checks++; if (o_bubble_cnt !== 2'd3) begin errors++; $display("FAIL b2b_cnt: got %0d expected 3", o_bubble_cnt); end
  endtask

  task automatic test_saturation;
    logic [1:0] expCnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    @(negedge clk);
    rst = 1;
    #1 rst = 0;
    // a load reading its own destination alternates capture and bubble
    setLoad(5'd5, 5'd5);
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (o_bubble_cnt !== expCnt[i]) begin errors++; $display("FAIL sat_cnt%0d: got %0d expected %0d", i, o_bubble_cnt, expCnt[i]); end
      tick();
    end
  endtask

  initial begin
    i_enable = 1;
    clearIn();
    test_reset_initial();
    test_passthrough();
    test_load_use();
    test_reset_async();
    test_no_dependence();
    test_flush();
    test_enable();
    test_back_to_back();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
